// File: rtl/alu_cmd_sequencer.sv
// Requester-side front end for the 32-bit ALU: accepts tagged requests, holds
// registered operands for a settle time, then returns a tagged result with flags.
module alu_cmd_sequencer #(
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    input  logic             clr_counts,
    output logic [15:0]      op_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SUB      = 4'd1;
    localparam logic [3:0] OP_LAST     = 4'd5;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       op_legal;
    logic       rsp_fire;
    logic       capture;
    logic       flag_carry;
    logic       flag_overflow;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    assign accept   = req_valid && (state == IDLE);
    assign op_legal = (req_op <= OP_LAST);
    assign rsp_fire = (state == RESP) && rsp_ready;
    assign capture  = (state == WAIT) && (settle_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = op_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (settle_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Flags are derived from the operands actually presented to the ALU.
    always_comb begin
        flag_carry    = 1'b0;
        flag_overflow = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                flag_carry    = (alu_result < alu_a);
                flag_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            OP_SUB: begin
                flag_carry    = (alu_a < alu_b);
                flag_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            default: begin
                flag_carry    = 1'b0;
                flag_overflow = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (accept && op_legal) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == WAIT) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Illegal requests never touch the ALU inputs, so they stay at the last legal op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_opcode <= 4'd0;
        end else if (accept && op_legal) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= req_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            rsp_tag    <= '0;
        end else if (accept) begin
            rsp_tag <= req_tag;
            if (!op_legal) begin
                rsp_result <= 32'd0;
                rsp_flags  <= 4'b1000;
            end
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= {1'b0, flag_carry, flag_overflow, alu_zero};
        end
    end

    // A clear takes priority over a same-cycle handshake increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= 16'd0;
            err_count <= 8'd0;
        end else if (clr_counts) begin
            op_count  <= 16'd0;
            err_count <= 8'd0;
        end else if (rsp_fire) begin
            if (rsp_flags[3]) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a transaction-level model is compared
// against the DUT every cycle, plus literal checks taken from the test plan.
module tb_alu_cmd_sequencer;

    localparam int TAG_W  = 4;
    localparam int S_MAIN = 1;
    localparam int S_LONG = 4;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_opcode;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             clr_counts;
    logic [15:0]      op_count;
    logic [7:0]       err_count;

    logic             l_req_valid;
    logic             l_req_ready;
    logic [31:0]      l_req_a;
    logic [31:0]      l_req_b;
    logic [3:0]       l_req_op;
    logic [TAG_W-1:0] l_req_tag;
    logic [31:0]      l_alu_a;
    logic [31:0]      l_alu_b;
    logic [3:0]       l_alu_opcode;
    logic [31:0]      l_alu_result;
    logic             l_alu_zero;
    logic             l_rsp_valid;
    logic [31:0]      l_rsp_result;
    logic [3:0]       l_rsp_flags;
    logic [TAG_W-1:0] l_rsp_tag;
    logic             l_busy;
    logic [15:0]      l_op_count;
    logic [7:0]       l_err_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    bit load_tog = 1'b0;
    bit load_seen = 1'b0;

    alu_cmd_sequencer #(.TAG_W(TAG_W), .SETTLE_CYCLES(S_MAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy), .clr_counts(clr_counts),
        .op_count(op_count), .err_count(err_count)
    );

    alu_cmd_sequencer #(.TAG_W(TAG_W), .SETTLE_CYCLES(S_LONG)) dut_long (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l_req_valid), .req_ready(l_req_ready),
        .req_a(l_req_a), .req_b(l_req_b), .req_op(l_req_op), .req_tag(l_req_tag),
        .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_opcode(l_alu_opcode),
        .alu_result(l_alu_result), .alu_zero(l_alu_zero),
        .rsp_valid(l_rsp_valid), .rsp_ready(1'b1),
        .rsp_result(l_rsp_result), .rsp_flags(l_rsp_flags), .rsp_tag(l_rsp_tag),
        .busy(l_busy), .clr_counts(1'b0),
        .op_count(l_op_count), .err_count(l_err_count)
    );

    // The combinational ALU the sequencer talks to.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_opcode);
        alu_zero   = (alu_result == 32'd0);
    end

    always_comb begin
        l_alu_result = alu_fn(l_alu_a, l_alu_b, l_alu_opcode);
        l_alu_zero   = (l_alu_result == 32'd0);
    end

    // Expected flags from wide unsigned/signed arithmetic.
    function automatic logic [3:0] exp_flags_fn(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] op);
        logic [32:0] wide;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        longint      sr;
        logic        c;
        logic        v;
        r  = alu_fn(a, b, op);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        if (op == 4'd0) begin
            wide = {1'b0, a} + {1'b0, b};
            c    = wide[32];
            sr   = sa + sb;
            v    = (sr > S_MAX) || (sr < S_MIN);
        end else if (op == 4'd1) begin
            c  = (a < b);
            sr = sa - sb;
            v  = (sr > S_MAX) || (sr < S_MIN);
        end
        return {1'b0, c, v, (r == 32'd0)};
    endfunction

    bit          m_busy;
    int          m_delay;
    logic [31:0] m_res;
    logic [3:0]  m_flags;
    logic [3:0]  m_tag;
    logic [31:0] m_alu_a;
    logic [31:0] m_alu_b;
    logic [3:0]  m_alu_op;
    int unsigned m_ops;
    int unsigned m_errs;

    // Transaction model: one request in flight, response after a fixed delay.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_delay  = 0;
            m_res    = 32'd0;
            m_flags  = 4'd0;
            m_tag    = 4'd0;
            m_alu_a  = 32'd0;
            m_alu_b  = 32'd0;
            m_alu_op = 4'd0;
            m_ops    = 0;
            m_errs   = 0;
        end else begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1;
                    m_tag  = req_tag;
                    if (req_op <= 4'd5) begin
                        m_alu_a  = req_a;
                        m_alu_b  = req_b;
                        m_alu_op = req_op;
                        m_res    = alu_fn(req_a, req_b, req_op);
                        m_flags  = exp_flags_fn(req_a, req_b, req_op);
                        m_delay  = S_MAIN;
                    end else begin
                        m_res   = 32'd0;
                        m_flags = 4'b1000;
                        m_delay = 0;
                    end
                end
            end else if (m_delay > 0) begin
                m_delay = m_delay - 1;
            end else if (rsp_ready) begin
                m_busy = 1'b0;
                if (m_flags[3]) m_errs = (m_errs >= 255) ? 255 : m_errs + 1;
                else            m_ops  = (m_ops >= 65535) ? 65535 : m_ops + 1;
            end
            if (clr_counts) begin
                m_ops  = 0;
                m_errs = 0;
            end
            if (load_tog != load_seen) begin
                load_seen = load_tog;
                m_ops     = 65535;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("cmp_req_ready", 32'(req_ready), 32'(!m_busy));
            check_output("cmp_busy", 32'(busy), 32'(m_busy));
            check_output("cmp_rsp_valid", 32'(rsp_valid), 32'(m_busy && (m_delay == 0)));
            if (m_busy && (m_delay == 0)) begin
                check_output("cmp_rsp_result", rsp_result, m_res);
                check_output("cmp_rsp_flags", 32'(rsp_flags), 32'(m_flags));
                check_output("cmp_rsp_tag", 32'(rsp_tag), 32'(m_tag));
            end
            check_output("cmp_alu_a", alu_a, m_alu_a);
            check_output("cmp_alu_b", alu_b, m_alu_b);
            check_output("cmp_alu_opcode", 32'(alu_opcode), 32'(m_alu_op));
            check_output("cmp_op_count", 32'(op_count), m_ops);
            check_output("cmp_err_count", 32'(err_count), m_errs);
        end
    end

    // Presents one request for exactly one clock edge; returns at the next falling edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [3:0] tag);
        @(negedge clk);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_a       = 32'd0;
        req_b       = 32'd0;
        req_op      = 4'd0;
        req_tag     = 4'd0;
        rsp_ready   = 1'b1;
        clr_counts  = 1'b0;
        l_req_valid = 1'b0;
        l_req_a     = 32'd0;
        l_req_b     = 32'd0;
        l_req_op    = 4'd0;
        l_req_tag   = 4'd0;
        #2;
        check_output("reset_req_ready", 32'(req_ready), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        check_output("reset_alu_a", alu_a, 32'd0);
        check_output("reset_op_count", 32'(op_count), 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Long settle instance: SHL 1 by 31.
        @(negedge clk);
        l_req_a     = 32'd1;
        l_req_b     = 32'd31;
        l_req_op    = 4'd5;
        l_req_tag   = 4'd7;
        l_req_valid = 1'b1;
        @(negedge clk);
        l_req_valid = 1'b0;
        check_output("long_busy", 32'(l_busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_output("long_latency_early", 32'(l_rsp_valid), 32'd0);
        end
        @(negedge clk);
        check_output("long_rsp_valid", 32'(l_rsp_valid), 32'd1);
        check_output("long_rsp_result", l_rsp_result, 32'h8000_0000);
        check_output("long_rsp_flags", 32'(l_rsp_flags), 32'h0);
        check_output("long_rsp_tag", 32'(l_rsp_tag), 32'd7);
        @(negedge clk);
        check_output("long_op_count", 32'(l_op_count), 32'd1);

        // ADD wrap to zero.
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 4'd0, 4'd3);
        check_output("add_not_yet_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_output("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("add_rsp_result", rsp_result, 32'd0);
        check_output("add_rsp_flags", 32'(rsp_flags), 32'b0101);
        check_output("add_rsp_tag", 32'(rsp_tag), 32'd3);
        @(negedge clk);
        check_output("add_op_count", 32'(op_count), 32'd1);

        // SUB signed overflow.
        apply_stimulus(32'h8000_0000, 32'd1, 4'd1, 4'd4);
        @(negedge clk);
        check_output("sub_rsp_result", rsp_result, 32'h7FFF_FFFF);
        check_output("sub_rsp_flags", 32'(rsp_flags), 32'b0010);

        // Illegal opcode.
        apply_stimulus(32'h1234, 32'h5678, 4'hA, 4'd5);
        check_output("ill_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("ill_rsp_result", rsp_result, 32'd0);
        check_output("ill_rsp_flags", 32'(rsp_flags), 32'b1000);
        check_output("ill_rsp_tag", 32'(rsp_tag), 32'd5);
        check_output("ill_alu_a", alu_a, 32'h8000_0000);
        check_output("ill_alu_opcode", 32'(alu_opcode), 32'd1);
        @(negedge clk);
        check_output("ill_err_count", 32'(err_count), 32'd1);
        check_output("ill_op_count", 32'(op_count), 32'd2);

        // XOR under backpressure; a stray request during RESP must be ignored.
        rsp_ready = 1'b0;
        apply_stimulus(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd4, 4'd9);
        @(negedge clk);
        req_a     = 32'hDEAD_BEEF;
        req_op    = 4'd0;
        req_tag   = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_output("bp_rsp_result", rsp_result, 32'hFFFF_FFFF);
            check_output("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check_output("bp_still_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check_output("bp_req_ready_after", 32'(req_ready), 32'd1);
        check_output("bp_op_count", 32'(op_count), 32'd3);
        check_output("bp_alu_a", alu_a, 32'hF0F0_F0F0);

        // Reset while waiting aborts the op.
        apply_stimulus(32'd5, 32'd6, 4'd0, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_req_ready", 32'(req_ready), 32'd1);
        check_output("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("abort_alu_a", alu_a, 32'd0);
        check_output("abort_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Error counter saturation.
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(32'(i), 32'(~i), 4'(6 + (i % 10)), 4'(i));
        end
        @(negedge clk);
        check_output("err_saturated", 32'(err_count), 32'hFF);
        check_output("err_sat_op_count", 32'(op_count), 32'd0);

        // Op counter saturation from a preloaded value.
        #2;
        force dut.op_count = 16'hFFFF;
        load_tog = ~load_tog;
        @(negedge clk);
        #2;
        release dut.op_count;
        @(negedge clk);
        check_output("preload_op_count", 32'(op_count), 32'hFFFF);
        apply_stimulus(32'hFF, 32'h0F, 4'd2, 4'd2);
        @(negedge clk);
        check_output("and_rsp_result", rsp_result, 32'h0F);
        check_output("and_rsp_flags", 32'(rsp_flags), 32'h0);
        @(negedge clk);
        check_output("op_saturated", 32'(op_count), 32'hFFFF);

        // Clear coinciding with a handshake.
        rsp_ready = 1'b0;
        apply_stimulus(32'd1, 32'd2, 4'd3, 4'd4);
        @(negedge clk);
        check_output("or_rsp_result", rsp_result, 32'd3);
        clr_counts = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        check_output("clr_op_count", 32'(op_count), 32'd0);
        check_output("clr_err_count", 32'(err_count), 32'd0);
        check_output("clr_req_ready", 32'(req_ready), 32'd1);

        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Requester-side front end for the team's 32-bit combinational ALU (ops ADD/SUB/AND/OR/XOR/SHL).
- Accepts tagged operation requests on a valid/ready interface, validates the opcode, and drives registered operands/opcode into the ALU.
- Waits a programmable settle time, captures result plus locally computed flags, and returns a tagged response under backpressure.
- Keeps saturating operation and error counters.

Parameters:
- TAG_W, 4, width of request/response tag.
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before result capture (legal range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL; 6..15 illegal
- req_tag  in  TAG_W  request tag
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_flags  out  4  {err, carry, overflow, zero}
- rsp_tag  out  TAG_W  tag of the request
- busy  out  1  state != IDLE
- clr_counts  in  1  synchronous clear of both counters
- op_count  out  16  legal responses delivered, saturating
- err_count  out  8  illegal-opcode responses delivered, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, except req_ready=1 (valid while rst_n=0 and in IDLE). Counters 0. An in-flight op is dropped with no response.
- States: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in RESP.
  - busy=1 in WAIT or RESP.
- IDLE, req_valid=1, req_op<=5 (legal):
  - Load alu_a/alu_b/alu_opcode and tag.
  - Load settle counter = SETTLE_CYCLES-1.
  - Go to WAIT.
- IDLE, req_valid=1, illegal opcode:
  - alu_* keep previous values.
  - rsp_result=0, rsp_flags=4'b1000, tag loaded.
  - Go directly to RESP.
- WAIT:
  - Counter !=0: decrement.
  - Counter ==0: on next edge capture alu_result into rsp_result, compute flags, go to RESP.
  - Legal latency: accept edge to rsp_valid = SETTLE_CYCLES cycles. Illegal latency: 0 cycles (rsp_valid high after the accept edge).
- Flags (computed from alu_a, alu_b, alu_opcode, alu_result):
  - zero = alu_zero.
  - ADD: carry = (alu_result < alu_a) unsigned; overflow = (a[31]==b[31]) && (r[31]!=a[31]).
  - SUB: carry (borrow) = (alu_a < alu_b) unsigned; overflow = (a[31]!=b[31]) && (r[31]!=a[31]).
  - AND/OR/XOR/SHL: carry=0, overflow=0.
  - err=0 for all legal ops.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, next edge returns to IDLE. No same-cycle turnaround: req_ready rises the cycle after the response handshake.
- Counters:
  - op_count +1 on each legal response handshake; err_count +1 on each illegal response handshake.
  - Both saturate: 16'hFFFF and 8'hFF hold.
  - clr_counts zeroes both at the next edge and wins over a simultaneous increment.
- alu_* outputs remain stable from the accept edge until the next legal accept.
- req_* inputs are ignored outside IDLE.
- Async reset asserted in WAIT or RESP aborts immediately. The aborted op is not counted.

Test Plan:
- ADD: A=32'hFFFF_FFFF, B=1, op=0, tag=3, SETTLE=1, ALU model returns 0/zero=1 -> one cycle later rsp_valid=1, rsp_result=0, rsp_flags=4'b0101, rsp_tag=3; op_count=1 after handshake.
- SUB overflow: A=32'h8000_0000, B=1, op=1, ALU returns 32'h7FFF_FFFF -> rsp_flags=4'b0010 (overflow=1, carry=0, zero=0).
- Illegal op=4'hA, tag=5 -> rsp_valid the cycle after accept, rsp_result=0, rsp_flags=4'b1000, alu_* unchanged, err_count=1, op_count unchanged.
- Backpressure: XOR 32'hF0F0_F0F0^32'h0F0F_0F0F with rsp_ready=0 for 5 cycles -> rsp_result=32'hFFFF_FFFF held, req_ready=0 throughout; handshake on cycle 6, req_ready=1 the next cycle.
- SETTLE_CYCLES=4, SHL A=1, B=31 -> rsp_valid exactly 4 cycles after accept, rsp_result=32'h8000_0000, carry=overflow=0.
- Reset in WAIT: drop rst_n mid-operation -> outputs 0 immediately, req_ready=1, no response after release. Separately, saturation: preload op_count to 16'hFFFF, do one op -> stays 16'hFFFF; clr_counts asserted together with a handshake -> 0.
